// File: rtl/instruction_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_t : fetch FSM state encoding (IDLE / WAIT_MEM / DELIVER)
//   - WORD_W        : instruction and address width (16 bits)
//   - PC_STEP       : byte distance between consecutive instructions
//   - is_aligned()  : true when an address lands on an instruction boundary
// ----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

   localparam int unsigned WORD_W = 16;

   localparam logic [WORD_W-1:0] PC_STEP = 16'd2;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_MEM = 2'b01,
      DELIVER  = 2'b10
   } fetch_state_t;

   // Instructions are 16 bits wide, so every legal fetch address is even.
   function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
      return ~addr[0];
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Instruction memory read bus between the fetch unit and instruction memory.
//   out_MemReq   : read request, held high until the memory answers
//   out_MemAddr  : read address, equals the fetch PC
//   in_MemData   : read data, valid while in_MemReady is high
//   in_MemReady  : read completion strobe
// Modports:
//   master : fetch unit side (drives request and address)
//   slave  : memory side (drives data and ready)
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if;
   import instruction_fetch_unit_pkg::*;

   logic              out_MemReq;
   logic [WORD_W-1:0] out_MemAddr;
   logic [WORD_W-1:0] in_MemData;
   logic              in_MemReady;

   modport master (
      output out_MemReq,
      output out_MemAddr,
      input  in_MemData,
      input  in_MemReady
   );

   modport slave (
      input  out_MemReq,
      input  out_MemAddr,
      output in_MemData,
      output in_MemReady
   );

endinterface

// File: rtl/instruction_fetch_unit_timeout_counter.sv
// ----------------------------------------------------------------------------
// fetch_timeout_counter
// 8-bit watchdog counter for the fetch unit's memory wait.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   clear    : synchronous clear, wins over enable
//   enable   : count one cycle
//   terminal : high while the count sits one below TERMINAL, i.e. the next
//              enabled cycle is the TERMINAL-th one
// ----------------------------------------------------------------------------
module fetch_timeout_counter #(
   parameter int unsigned TERMINAL = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [7:0] LAST = 8'(TERMINAL - 1);

   logic [7:0] count;

   // Cycle counter: cleared whenever the owner is not waiting, so every
   // wait starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 8'd0;
      end else if (clear) begin
         count <= 8'd0;
      end else if (enable) begin
         count <= count + 8'd1;
      end
   end

   // The owner acts on terminal in the same cycle it is counting, so the
   // fault lands exactly on the edge where the count would reach TERMINAL.
   assign terminal = (count == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetches 16-bit instructions from instruction memory and hands them to the
// instruction register. Owns the fetch PC, the memory read handshake,
// branch/jump redirects and a memory timeout watchdog.
//
// Parameters:
//   RESET_PC        : fetch PC after reset (even)
//   TIMEOUT_CYCLES  : memory wait cycles tolerated before faulting (1..255)
// Ports:
//   CLK          : rising-edge clock
//   in_Reset_n   : asynchronous active-low reset
//   in_Fetch     : control unit requests the next instruction
//   in_Redirect  : load in_Target as the next fetch PC
//   in_Target    : redirect address
//   mem          : instruction memory read bus (master side)
//   out_Inst     : last delivered instruction, feeds the IR data input
//   out_IRWrite  : one-cycle IR write-enable pulse
//   out_PC       : address of the instruction last delivered
//   out_PCNext   : out_PC + 2, used as the link value
//   out_Busy     : high while a fetch is in flight (WAIT_MEM / DELIVER)
//   out_Fault    : sticky misaligned-redirect / memory-timeout flag
// ----------------------------------------------------------------------------
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC       = 16'h0000,
   parameter int unsigned       TIMEOUT_CYCLES = 255
) (
   input  logic                   CLK,
   input  logic                   in_Reset_n,
   input  logic                   in_Fetch,
   input  logic                   in_Redirect,
   input  logic [WORD_W-1:0]      in_Target,
   instruction_fetch_unit_if.master mem,
   output logic [WORD_W-1:0]      out_Inst,
   output logic                   out_IRWrite,
   output logic [WORD_W-1:0]      out_PC,
   output logic [WORD_W-1:0]      out_PCNext,
   output logic                   out_Busy,
   output logic                   out_Fault
);

   fetch_state_t      state;
   logic [WORD_W-1:0] fetch_pc;
   logic              kill;
   logic [WORD_W-1:0] kill_target;
   logic              mem_req_q;
   logic [WORD_W-1:0] inst_q;
   logic              ir_write_q;
   logic [WORD_W-1:0] pc_q;
   logic [WORD_W-1:0] pc_next_q;
   logic              busy_q;
   logic              fault_q;

   logic              redirect_ok;
   logic              redirect_bad;
   logic              in_wait;
   logic              wd_terminal;
   logic              timeout_hit;
   logic              kill_now;
   logic [WORD_W-1:0] kill_target_now;

   // Redirect qualification: only even targets are legal; an odd one is
   // dropped and raises the sticky fault instead.
   assign redirect_ok  = in_Redirect &  is_aligned(in_Target);
   assign redirect_bad = in_Redirect & ~is_aligned(in_Target);

   assign in_wait = (state == WAIT_MEM);

   // A redirect arriving in the same cycle as the memory answer must still
   // kill that answer, so the pending kill and the live redirect are merged
   // here, with the live redirect being the most recent target.
   assign kill_now        = kill | redirect_ok;
   assign kill_target_now = redirect_ok ? in_Target : kill_target;

   assign timeout_hit = in_wait & wd_terminal & ~mem.in_MemReady;

   // Watchdog for the memory wait: runs only in WAIT_MEM and restarts from
   // zero on every entry because it is held clear everywhere else.
   fetch_timeout_counter #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (CLK),
      .rst_n    (in_Reset_n),
      .clear    (~in_wait),
      .enable   (in_wait),
      .terminal (wd_terminal)
   );

   // Fetch FSM with all outputs registered. The address never changes while
   // a request is outstanding; redirects seen during WAIT_MEM are parked in
   // kill_target and only committed to fetch_pc when the fetch ends.
   always_ff @(posedge CLK or negedge in_Reset_n) begin
      if (!in_Reset_n) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         kill        <= 1'b0;
         kill_target <= RESET_PC;
         mem_req_q   <= 1'b0;
         inst_q      <= '0;
         ir_write_q  <= 1'b0;
         pc_q        <= RESET_PC;
         pc_next_q   <= RESET_PC + PC_STEP;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         ir_write_q <= 1'b0;

         if (redirect_bad) begin
            fault_q <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (redirect_ok) begin
                  fetch_pc <= in_Target;
               end
               // A misaligned redirect in the same cycle also blocks the
               // fetch, since the fault it raises would otherwise lag by one.
               if (in_Fetch && !fault_q && !redirect_bad) begin
                  state     <= WAIT_MEM;
                  mem_req_q <= 1'b1;
                  busy_q    <= 1'b1;
                  kill      <= 1'b0;
               end
            end

            WAIT_MEM: begin
               if (redirect_ok) begin
                  kill        <= 1'b1;
                  kill_target <= in_Target;
               end

               if (mem.in_MemReady) begin
                  mem_req_q <= 1'b0;
                  if (kill_now) begin
                     fetch_pc <= kill_target_now;
                     kill     <= 1'b0;
                     busy_q   <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     inst_q     <= mem.in_MemData;
                     ir_write_q <= 1'b1;
                     state      <= DELIVER;
                  end
               end else if (timeout_hit) begin
                  fault_q   <= 1'b1;
                  mem_req_q <= 1'b0;
                  busy_q    <= 1'b0;
                  kill      <= 1'b0;
                  state     <= IDLE;
                  if (kill_now) begin
                     fetch_pc <= kill_target_now;
                  end
               end
            end

            DELIVER: begin
               pc_q      <= fetch_pc;
               pc_next_q <= fetch_pc + PC_STEP;
               if (redirect_ok) begin
                  fetch_pc <= in_Target;
               end else begin
                  fetch_pc <= fetch_pc + PC_STEP;
               end
               busy_q <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               mem_req_q <= 1'b0;
               busy_q    <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign mem.out_MemReq  = mem_req_q;
   assign mem.out_MemAddr = fetch_pc;

   assign out_Inst    = inst_q;
   assign out_IRWrite = ir_write_q;
   assign out_PC      = pc_q;
   assign out_PCNext  = pc_next_q;
   assign out_Busy    = busy_q;
   assign out_Fault   = fault_q;

endmodule
